// File: rtl/rm_pkg.sv
// Shared constants and FSM state type for the random-modulo control generator.
package rm_pkg;

  localparam int unsigned RM_SEED_WIDTH = 32;
  localparam logic [RM_SEED_WIDTH-1:0] RM_LFSR_POLY  = 32'h80200003;
  localparam logic [RM_SEED_WIDTH-1:0] RM_SEED_RESET = 32'hACE11DEA;

  typedef enum logic [1:0] {RM_IDLE, RM_DRAIN, RM_STEP, RM_DONE} rm_gen_state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by the reset seed.
  function automatic logic [RM_SEED_WIDTH-1:0] rm_nonzero_seed(
    input logic [RM_SEED_WIDTH-1:0] value
  );
    return (value == '0) ? RM_SEED_RESET : value;
  endfunction

endpackage

// File: rtl/rm_lfsr_step.sv
// Single combinational Galois LFSR advance of the cache seed.
module rm_lfsr_step
  import rm_pkg::*;
(
  input  logic [RM_SEED_WIDTH-1:0] seed_i,
  output logic [RM_SEED_WIDTH-1:0] seed_o
);

  always_comb begin
    seed_o = (seed_i >> 1) ^ (seed_i[0] ? RM_LFSR_POLY : '0);
  end

endmodule

// File: rtl/rm_control_gen.sv
// Benes control-word generator: hashes lookup tags with a secret seed and owns the reseed FSM.
// Define RM_AUTO_RESEED_EN to reseed automatically after 65535 accepted lookups.
module rm_control_gen
  import rm_pkg::*;
#(
  parameter int unsigned TAG_WIDTH    = 20,
  parameter int unsigned CNT          = 3,
  parameter int unsigned RESEED_STEPS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lookup_valid,
  input  logic [TAG_WIDTH-1:0]     lookup_tag,
  output logic                     lookup_ready,
  output logic                     ctrl_valid,
  output logic [CNT-1:0]           ctrl_o,
  input  logic                     reseed_req,
  output logic                     reseed_ack,
  input  logic                     seed_load_en,
  input  logic [RM_SEED_WIDTH-1:0] seed_load_value,
  output logic [RM_SEED_WIDTH-1:0] cur_seed
);

  localparam int unsigned StepW = (RESEED_STEPS > 1) ? $clog2(RESEED_STEPS) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(RESEED_STEPS - 1);

  rm_gen_state_t            state_q;
  logic [RM_SEED_WIDTH-1:0] seed_q;
  logic [RM_SEED_WIDTH-1:0] seed_step;
  logic [StepW-1:0]         step_cnt_q;
  logic                     ctrl_valid_q;
  logic [CNT-1:0]           ctrl_q;
  logic                     ack_q;
  logic [TAG_WIDTH-1:0]     hash;
  logic [CNT-1:0]           ctrl_fold;
  logic                     accept;
  logic                     req_any;

  assign lookup_ready = (state_q == RM_IDLE);
  assign accept       = lookup_valid && lookup_ready;

  rm_lfsr_step u_lfsr_step (
    .seed_i (seed_q),
    .seed_o (seed_step)
  );

  // Tag bit j feeds control bit (j mod CNT).
  always_comb begin
    hash      = lookup_tag ^ seed_q[TAG_WIDTH-1:0];
    ctrl_fold = '0;
    for (int i = 0; i < int'(CNT); i++) begin
      for (int j = 0; j < int'(TAG_WIDTH); j++) begin
        if ((j % int'(CNT)) == i) begin
          ctrl_fold[i] = ctrl_fold[i] ^ hash[j];
        end
      end
    end
  end

`ifdef RM_AUTO_RESEED_EN
  logic [15:0] lookup_cnt_q;
  logic        auto_req;

  assign auto_req = (lookup_cnt_q == 16'hFFFF);
  assign req_any  = reseed_req || auto_req;

  always_ff @(posedge clk) begin
    if (reset || state_q == RM_DONE) begin
      lookup_cnt_q <= '0;
    end else if (accept && !auto_req) begin
      lookup_cnt_q <= lookup_cnt_q + 16'd1;
    end
  end
`else
  assign req_any = reseed_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RM_IDLE;
      seed_q       <= RM_SEED_RESET;
      step_cnt_q   <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_q       <= '0;
      ack_q        <= 1'b0;
    end else begin
      ctrl_valid_q <= accept;
      if (accept) begin
        ctrl_q <= ctrl_fold;
      end
      ack_q <= 1'b0;
      case (state_q)
        RM_IDLE: begin
          // A load wins over a same-cycle request; the level-held request is taken next cycle.
          if (seed_load_en) begin
            seed_q <= rm_nonzero_seed(seed_load_value);
          end else if (req_any) begin
            state_q <= RM_DRAIN;
          end
        end
        RM_DRAIN: begin
          if (!ctrl_valid_q) begin
            state_q <= RM_STEP;
          end
        end
        RM_STEP: begin
          seed_q <= seed_step;
          if (step_cnt_q == StepLast) begin
            step_cnt_q <= '0;
            state_q    <= RM_DONE;
            ack_q      <= 1'b1;
          end else begin
            step_cnt_q <= step_cnt_q + 1'b1;
          end
        end
        RM_DONE: begin
          state_q <= RM_IDLE;
        end
        default: begin
          state_q <= RM_IDLE;
        end
      endcase
    end
  end

  assign ctrl_valid = ctrl_valid_q;
  assign ctrl_o     = ctrl_q;
  assign reseed_ack = ack_q;
  assign cur_seed   = seed_q;

endmodule

// File: tb/tb_rm_control_gen.sv
// Self-checking bench for rm_control_gen: timeline model plus directed literal checks.
module tb_rm_control_gen;
  import rm_pkg::*;

  localparam int TW = 20;
  localparam int NS = 4;

  logic        clk;
  logic        reset;
  logic        lookup_valid;
  logic [19:0] lookup_tag;
  logic        lookup_ready;
  logic        ctrl_valid;
  logic [2:0]  ctrl_o;
  logic        reseed_req;
  logic        reseed_ack;
  logic        seed_load_en;
  logic [31:0] seed_load_value;
  logic [31:0] cur_seed;

  int checks = 0;
  int errors = 0;

  rm_control_gen #(
    .TAG_WIDTH    (TW),
    .CNT          (3),
    .RESEED_STEPS (NS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_valid    (lookup_valid),
    .lookup_tag      (lookup_tag),
    .lookup_ready    (lookup_ready),
    .ctrl_valid      (ctrl_valid),
    .ctrl_o          (ctrl_o),
    .reseed_req      (reseed_req),
    .reseed_ack      (reseed_ack),
    .seed_load_en    (seed_load_en),
    .seed_load_value (seed_load_value),
    .cur_seed        (cur_seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 60) $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_n(input logic [31:0] s, input int k);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < k; i++) r = (r >> 1) ^ (r[0] ? 32'h80200003 : 32'h0);
    return r;
  endfunction

  function automatic logic [2:0] fold(input logic [19:0] h);
    logic [2:0] r;
    r = 3'b000;
    for (int j = 0; j < 20; j++) r[j % 3] = r[j % 3] ^ h[j];
    return r;
  endfunction

  // Model: a reseed taken in cycle t0 with d in-flight lookups has its first STEP cycle at
  // s = t0 + 2 + d; seed in cycle c is lfsr^(c-s) clamped to [0,NS]; ack when c == s + NS.
  int          cyc = 0;
  bit          m_init = 0;
  bit          m_busy = 0;
  int          m_s = 0;
  logic [31:0] m_base = '0;
  logic [31:0] m_seed = '0;
  bit          m_cv = 0;
  logic [2:0]  m_ctrl = '0;
  int          m_lcnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_init = 1; m_busy = 0; m_seed = 32'hACE11DEA; m_cv = 0; m_ctrl = '0; m_lcnt = 0;
      end else if (m_init) begin
        if (m_busy) begin
          m_cv = 0;
          if (cyc == m_s + NS) begin
            m_busy = 0; m_seed = lfsr_n(m_base, NS); m_lcnt = 0;
          end
        end else begin
          bit acc;
          bit req_eff;
          acc = lookup_valid;
          m_cv = acc;
          if (acc) m_ctrl = fold(lookup_tag ^ m_seed[19:0]);
          req_eff = reseed_req;
`ifdef RM_AUTO_RESEED_EN
          if (m_lcnt == 65535) req_eff = 1;
`endif
          if (acc && m_lcnt != 65535) m_lcnt++;
          if (seed_load_en) begin
            m_seed = (seed_load_value == 0) ? 32'hACE11DEA : seed_load_value;
          end else if (req_eff) begin
            m_busy = 1; m_base = m_seed; m_s = cyc + 2 + (acc ? 1 : 0);
          end
        end
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        logic [31:0] e_seed;
        bit e_ack;
        int rel;
        int k;
        e_seed = m_seed;
        e_ack  = 0;
        if (m_busy) begin
          rel = cyc - m_s;
          k = (rel < 0) ? 0 : ((rel > NS) ? NS : rel);
          e_seed = lfsr_n(m_base, k);
          e_ack = (rel == NS);
        end
        check("cyc_ready", {31'b0, lookup_ready}, {31'b0, !m_busy});
        check("cyc_ctrl_valid", {31'b0, ctrl_valid}, {31'b0, m_cv});
        check("cyc_ctrl_o", {29'b0, ctrl_o}, {29'b0, m_ctrl});
        check("cyc_ack", {31'b0, reseed_ack}, {31'b0, e_ack});
        check("cyc_seed", cur_seed, e_seed);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] v);
    seed_load_en = 1; seed_load_value = v;
    tick();
    seed_load_en = 0;
  endtask

  // Caller has set reseed_req (and maybe a lookup/load) for the first sampled edge.
  task automatic run_reseed(input int exp_n, input string nm, input bit drop_req,
                            input bit load_in_step, input bit chk_rdy);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      lookup_valid = 0;
      if (n == 1) begin
        seed_load_en = 0;
        if (drop_req) reseed_req = 0;
      end
      if (load_in_step && n == 2) begin
        seed_load_en = 1; seed_load_value = 32'h12345678;
      end
      if (load_in_step && n == 4) seed_load_en = 0;
      if (chk_rdy) check({nm, "_rdy"}, {31'b0, lookup_ready}, 32'd0);
    end while (!reseed_ack && n < 20);
    reseed_req = 0;
    check({nm, "_ack_cycle"}, n, exp_n);
  endtask

  initial begin
    bit seen;
    reset = 1; lookup_valid = 0; lookup_tag = '0; reseed_req = 0;
    seed_load_en = 0; seed_load_value = '0;
    tick();
    tick();
    reset = 0;
    check("rst_ready", {31'b0, lookup_ready}, 32'd1);
    check("rst_seed", cur_seed, 32'hACE11DEA);
    check("rst_ctrl_valid", {31'b0, ctrl_valid}, 32'd0);
    check("rst_ctrl_o", {29'b0, ctrl_o}, 32'd0);
    check("rst_ack", {31'b0, reseed_ack}, 32'd0);

    load_seed(32'h1);
    check("load1", cur_seed, 32'h1);
    lookup_valid = 1; lookup_tag = 20'h00001;
    tick();
    check("tag1_valid", {31'b0, ctrl_valid}, 32'd1);
    check("tag1_ctrl", {29'b0, ctrl_o}, 32'd0);
    lookup_tag = 20'h00007;
    tick();
    check("tag7_ctrl", {29'b0, ctrl_o}, 32'd6);
    lookup_tag = 20'h00009;
    tick();
    check("tag9_ctrl", {29'b0, ctrl_o}, 32'd1);
    lookup_valid = 0;
    tick();
    check("idle_valid", {31'b0, ctrl_valid}, 32'd0);
    check("idle_ctrl_hold", {29'b0, ctrl_o}, 32'd1);

    reseed_req = 1;
    run_reseed(6, "basic", 0, 0, 1);
    check("basic_seed", cur_seed, 32'hB02C0003);
    tick();
    check("model_seed_pin", m_seed, 32'hB02C0003);
    check("basic_back_idle", {31'b0, lookup_ready}, 32'd1);

    load_seed(32'h1);
    lookup_valid = 1; lookup_tag = 20'h00007; reseed_req = 1;
    run_reseed(7, "samecyc", 0, 0, 1);
    check("samecyc_ctrl_old_seed", {29'b0, ctrl_o}, 32'd6);
    check("samecyc_seed", cur_seed, 32'hB02C0003);
    tick();

    load_seed(32'h0);
    check("load_zero", cur_seed, 32'hACE11DEA);

    load_seed(32'h1);
    reseed_req = 1;
    run_reseed(6, "load_in_step", 0, 1, 0);
    check("load_in_step_seed", cur_seed, 32'hB02C0003);
    tick();
    check("load_in_step_idle_seed", cur_seed, 32'hB02C0003);

    seed_load_en = 1; seed_load_value = 32'h1; reseed_req = 1;
    run_reseed(7, "load_and_req", 0, 0, 0);
    check("load_and_req_seed", cur_seed, 32'hB02C0003);
    tick();

    load_seed(32'h1);
    reseed_req = 1;
    run_reseed(6, "drop_req", 1, 0, 0);
    check("drop_req_seed", cur_seed, 32'hB02C0003);
    tick();

    load_seed(32'h1);
    reseed_req = 1;
    tick();
    tick();
    tick();
    reset = 1; reseed_req = 0;
    tick();
    reset = 0;
    check("midrst_ready", {31'b0, lookup_ready}, 32'd1);
    check("midrst_seed", cur_seed, 32'hACE11DEA);
    check("midrst_ctrl_valid", {31'b0, ctrl_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (reseed_ack) seen = 1;
      tick();
    end
    check("midrst_no_ack", {31'b0, seen}, 32'd0);

    lookup_valid = 1;
    for (int i = 0; i < 65535; i++) begin
      lookup_tag = 20'($urandom_range(0, 20'hFFFFF));
      tick();
    end
    lookup_valid = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (reseed_ack) seen = 1;
      tick();
    end
`ifdef RM_AUTO_RESEED_EN
    check("auto_reseed_ack", {31'b0, seen}, 32'd1);
`else
    check("auto_reseed_absent", {31'b0, seen}, 32'd0);
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rm_control_gen.md
Name: rm_control_gen

Overview:
- Upstream control stage for the 3-input random-modulo Benes permutation used in L1 cache set indexing.
- Hashes each lookup's address tag with a per-cache secret seed and produces the CNT-bit Benes control word one cycle later.
- Owns the seed: Galois-LFSR reseed sequencer with drain/step/ack handshake, plus direct seed load for context switches.

Parameters:
- TAG_WIDTH, 20, address tag bits hashed into control; must be <= RM_SEED_WIDTH.
- CNT, 3, Benes control bits produced; must be >= 1.
- RESEED_STEPS, 4, LFSR advances per reseed; must be >= 1.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- lookup_valid  in  1  tag presented this cycle.
- lookup_tag  in  TAG_WIDTH  address tag to hash.
- lookup_ready  out  1  lookup accepted when lookup_valid && lookup_ready.
- ctrl_valid  out  1  ctrl_o holds the result of an accepted lookup.
- ctrl_o  out  CNT  Benes control word.
- reseed_req  in  1  level request; held high until reseed_ack.
- reseed_ack  out  1  one-cycle pulse: new seed in effect.
- seed_load_en  in  1  load seed_load_value (honoured in IDLE only).
- seed_load_value  in  RM_SEED_WIDTH  seed to load.
- cur_seed  out  RM_SEED_WIDTH  current seed (debug/verification).

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: seed=RM_SEED_RESET, state=IDLE, ctrl_valid=0, ctrl_o=0, reseed_ack=0, step counter=0. lookup_ready=1 from the first cycle after reset.
- Hash: h = lookup_tag ^ seed[TAG_WIDTH-1:0]. ctrl[i] = XOR of all h[j] with j mod CNT == i.
- Latency is 1 cycle. ctrl_valid and ctrl_o are registered on an accepted lookup. ctrl_valid=0 in any cycle after no accept; ctrl_o holds its last value.
- lookup_ready = (state==IDLE), combinational from state only.
- FSM transitions:
  - IDLE -> DRAIN when reseed_req=1. A lookup accepted in the same cycle completes under the old seed.
  - DRAIN -> STEP when ctrl_valid==0; otherwise stay in DRAIN.
  - STEP: one LFSR advance per cycle. Counter counts 0..RESEED_STEPS-1, then go to DONE.
  - DONE: reseed_ack=1 for this cycle only, then return to IDLE.
- LFSR advance: seed = (seed>>1) ^ (seed[0] ? RM_LFSR_POLY : 0).
- seed_load_en in IDLE loads seed_load_value; a value of 0 is replaced by RM_SEED_RESET, because 0 locks the LFSR. seed_load_en outside IDLE is ignored.
- seed_load_en and reseed_req in the same IDLE cycle: the load is performed and the request is not taken that cycle. It is taken next cycle because the request is level-held.
- reseed_req dropped mid-sequence: the sequence still completes and acks.
- Reset mid-sequence: return to IDLE, seed=RM_SEED_RESET, no ack.
- Uncontended reseed: ack arrives RESEED_STEPS+2 cycles after the request is sampled.

Optional Feature:
- Macro RM_AUTO_RESEED_EN.
- With the macro: a 16-bit counter of accepted lookups. When it saturates at 16'hFFFF, an internal request behaves exactly like reseed_req, the counter clears, and reseed_ack pulses as normal. The counter also clears on reset and on any completed reseed.
- Without the macro: no counter; reseeds are external only.

Decomposition:
- Package rm_pkg holds:
  - localparam RM_SEED_WIDTH=32
  - RM_LFSR_POLY=32'h80200003
  - RM_SEED_RESET=32'hACE11DEA
  - typedef enum rm_gen_state_t {RM_IDLE, RM_DRAIN, RM_STEP, RM_DONE}
- One sub-module: rm_lfsr_step, a combinational single Galois step, reused for the reseed path.
- The hash fold stays inline in rm_control_gen.

Test Plan:
- Reset, load seed 0x00000001; lookup tag 0x00001 -> next cycle ctrl_valid=1, ctrl_o=3'b000. Tag 0x00007 -> 3'b110. Tag 0x00009 -> 3'b001.
- Seed 0x00000001, assert reseed_req with no lookups -> states DRAIN, STEP x4, DONE; reseed_ack pulses 6 cycles after request; cur_seed=0xB02C0003; lookup_ready=0 throughout the sequence.
- Lookup accepted in the same cycle as reseed_req -> ctrl_o computed with the old seed; DRAIN lasts 2 cycles; ack at cycle 7.
- seed_load_value=0 -> cur_seed=0xACE11DEA. seed_load_en during STEP -> ignored, and the final seed matches the pure LFSR result.
- Reset asserted during STEP -> next cycle IDLE, cur_seed=0xACE11DEA, ctrl_valid=0, no reseed_ack.
- With RM_AUTO_RESEED_EN: 65535 back-to-back lookups -> an internal reseed starts and reseed_ack pulses. Without the macro, the same stimulus produces no reseed.
